rr_arb4: RTL

- Four-requester round-robin arbiter with grant hold and timeout, sequencing access to one shared resource.
- Its any-request term is the 4-input OR of the request lines.
- Sits between four requesters and the resource they share, e.g. a shared LUT/EBR port or output mux select.
- Grants are registered and one-hot. The holder keeps the grant while its request stays high, bounded by a hold timeout.

---
 rtl/rr_arb4.sv | 123 ++++++++++++
 1 files changed

// File: rtl/rr_arb4.sv
// Four-requester round-robin arbiter with registered one-hot grant, grant hold
// while the request stays high, and an optional hold timeout that forces a handoff.
module rr_arb4 #(
  parameter int MAX_HOLD = 16,
  parameter int PTR_INIT = 0
) (
  input  logic       CK,
  input  logic       RSTN,
  input  logic [3:0] REQ,
  output logic [3:0] GNT,
  output logic [1:0] GID,
  output logic       BUSY,
  output logic       ANYREQ,
  output logic       TMO
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  localparam logic [1:0] PTR_RST   = 2'(PTR_INIT);

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] gnt_d;
  logic [1:0] gid_d;
  logic       busy_d, tmo_d;

  logic [3:0] arb_req;
  logic [1:0] arb_start;
  logic       rearb;
  logic [2:0] win;

  // Returns {found, index}; the lowest circular offset from start wins.
  function automatic logic [2:0] arb(input logic [3:0] req, input logic [1:0] start);
    logic [2:0] r;
    logic [1:0] idx;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (req[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  assign ANYREQ = |REQ;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    gnt_d     = GNT;
    gid_d     = GID;
    busy_d    = BUSY;
    tmo_d     = 1'b0;
    arb_req   = REQ;
    arb_start = ptr_q;
    rearb     = 1'b0;

    case (state_q)
      IDLE: rearb = 1'b1;
      GRANT: begin
        if (!REQ[GID]) begin
          ptr_d     = GID + 2'd1;
          cnt_d     = 8'd0;
          arb_start = GID + 2'd1;
          rearb     = 1'b1;
        end else if (MAX_HOLD != 0 && cnt_q == HOLD_LAST) begin
          // Forced release: the timed-out holder is excluded from this edge's search.
          tmo_d     = 1'b1;
          ptr_d     = GID + 2'd1;
          cnt_d     = 8'd0;
          arb_req   = REQ & ~(4'b0001 << GID);
          arb_start = GID + 2'd1;
          rearb     = 1'b1;
        end else if (cnt_q != 8'hff) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    win = arb(arb_req, arb_start);

    if (rearb) begin
      if (win[2]) begin
        gnt_d   = 4'b0001 << win[1:0];
        gid_d   = win[1:0];
        busy_d  = 1'b1;
        cnt_d   = 8'd0;
        state_d = GRANT;
      end else begin
        gnt_d   = 4'b0000;
        gid_d   = 2'd0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CK) begin
    if (!RSTN) begin
      state_q <= IDLE;
      ptr_q   <= PTR_RST;
      cnt_q   <= 8'd0;
      GNT     <= 4'b0000;
      GID     <= 2'd0;
      BUSY    <= 1'b0;
      TMO     <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      GNT     <= gnt_d;
      GID     <= gid_d;
      BUSY    <= busy_d;
      TMO     <= tmo_d;
    end
  end

endmodule
